ddr2_cmd_sequencer: RTL and testbench
=====================================

# ddr2_cmd_sequencer

Controller-side DDR2 command sequencer. It accepts single-beat read and write requests from the controller front end and drives the DDR2 command/address pins of the DIMM using a closed-page policy: ACTIVATE, then READ or WRITE with auto-precharge. It also issues periodic AUTO REFRESH commands. It sits between the request arbiter and the DIMM command bus, and signals the data path when a column command has been issued.

## Interface
Parameters:
- T_RCD, 3: cycles from ACT to RD/WR (ACT cycle counts as 1).
- T_AP, 8: cycles from RD/WR until the sequencer may issue the next command. Covers tRAS, tWR/tRTP and tRP under auto-precharge.
- T_RFC, 26: cycles from REF until the sequencer may issue the next command.
- T_REFI, 1560: refresh interval in cycles.

Ports:
- clk  in  1  controller clock, same frequency as the DDR2 ck.
- rst_n  in  1  asynchronous active-low reset.
- init_done  in  1  DRAM initialization complete; no commands are issued while low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid & ready at a rising clk.
- req_write  in  1  1 = write, 0 = read.
- req_bank  in  2  bank.
- req_row  in  15  row.
- req_col  in  10  column.
- cke  out  1  clock enable.
- cs_n, ras_n, cas_n, we_n  out  1 each  command pins.
- ba  out  2  bank address.
- addr  out  15  row/column address.
- rd_issued  out  1  one-cycle pulse, coincident with the RD command cycle.
- wr_issued  out  1  one-cycle pulse, coincident with the WR command cycle.
- ref_busy  out  1  high from REF issue through the end of T_RFC.

## Operation
- Command encoding {cs_n,ras_n,cas_n,we_n}:
  - NOP 0111
  - ACT 0011
  - RD 0101
  - WR 0100
  - REF 0001
  - deselect 1111 (reset only)
- All pin outputs are registered; exactly one command per cycle; NOP in every cycle without a command.
- States:
  - IDLE. If init_done & ref_pending, go to REF. Else if req_valid & req_ready, latch the request and go to ACT.
  - ACT. Drive ACT with ba=bank, addr=row. Go to RCD.
  - RCD. Count T_RCD-1 NOP cycles, then go to RW. If T_RCD=1, go directly to RW.
  - RW. Drive RD or WR with ba=bank, addr={4'b0, 1'b1, col}; addr[10]=1 selects auto-precharge. Pulse rd_issued or wr_issued. Go to WAIT.
  - WAIT. Count T_AP-1 NOP cycles, then go to IDLE.
  - REF. Drive REF, ba=0, addr=0. Clear ref_pending. Go to RFC.
  - RFC. Count T_RFC-1 NOP cycles, then go to IDLE.
- req_ready = (state==IDLE) & init_done & !ref_pending. This is combinational from registered state.
- Refresh timer:
  - Free-running counter 0..T_REFI-1, enabled only when init_done=1.
  - On wrap it sets ref_pending.
  - Refresh has priority over a simultaneously valid request.
  - If a wrap occurs while ref_pending is already set, the flag stays set; at most one refresh is owed. Legal parameters guarantee T_REFI > T_RFC + T_RCD + T_AP.
- Wait counters are sized by $clog2 of the largest parameter, load on state entry, and count down to 1.
- init_done low in IDLE: no accept, no refresh, timer held at 0. A drop of init_done mid-sequence does not abort the sequence; it blocks the next accept.

## Timing
- Reset values:
  - cke=0; cs_n=ras_n=cas_n=we_n=1; ba=0; addr=0.
  - rd_issued=wr_issued=0; ref_busy=0; state IDLE; ref_pending=0; refresh counter 0.
- cke goes to 1 on the first rising clk after rst_n deasserts; pins go to NOP on the same edge.
- Request latency: with acceptance at edge k, the sequencer drives
  - ACT in cycle k+1,
  - RD/WR in cycle k+1+T_RCD,
  - req_ready high again in cycle k+1+T_RCD+T_AP (the first cycle back in IDLE).
- Refresh: with ref_pending seen in IDLE at edge k, REF is in cycle k+1, ref_busy is high in cycles k+1..k+T_RFC, and IDLE is reached in cycle k+1+T_RFC.
- Back-to-back requests: minimum spacing between ACT commands is T_RCD+T_AP+1 cycles.
- Async reset mid-sequence: all outputs return to their reset values immediately, the latched request is dropped, and pending refresh is cleared.

## Test plan
- Read, defaults, bank 2, row 0x1234, col 0x05A, accepted at edge 10:
  - cycle 11: ACT, ba=2, addr=0x1234.
  - cycle 14: RD, addr=0x045A, rd_issued=1.
  - cycle 22: ready=1.
- Write with T_RCD=1, bank 1, col 0x3FF:
  - WR immediately follows ACT, addr=0x07FF, wr_issued pulses for exactly 1 cycle.
- Refresh collision: req_valid held high as ref_pending rises in IDLE:
  - REF is issued first, ready stays 0 for T_RFC+1 cycles.
  - ACT follows 1 cycle after returning to IDLE.
- Refresh period, T_REFI=100, no traffic: REF appears every 100 cycles, ref_busy is high for 26 cycles each time.
- Reset mid-WAIT (rst_n low for 3 cycles):
  - pins are deselect with cke=0 during reset.
  - after release: NOP, ready=1 when init_done=1, no stale RD/WR.
- init_done=0: req_valid held for 50 cycles produces no commands and ready=0. After init_done rises, the request is accepted the same cycle.

Source files
------------

// File: rtl/ddr2_cmd_sequencer.sv
// DDR2 command sequencer: closed-page ACT -> RD/WR with auto-precharge, plus periodic AUTO REFRESH.
// Pins are registered and decoded from the next state, so each command appears in the cycle its state is entered.
module ddr2_cmd_sequencer #(
  parameter int T_RCD  = 3,
  parameter int T_AP   = 8,
  parameter int T_RFC  = 26,
  parameter int T_REFI = 1560
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_done,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_bank,
  input  logic [14:0] req_row,
  input  logic [9:0]  req_col,
  output logic        cke,
  output logic        cs_n,
  output logic        ras_n,
  output logic        cas_n,
  output logic        we_n,
  output logic [1:0]  ba,
  output logic [14:0] addr,
  output logic        rd_issued,
  output logic        wr_issued,
  output logic        ref_busy
);

  localparam int MAX_RA = (T_RCD > T_AP) ? T_RCD : T_AP;
  localparam int MAX_T  = (MAX_RA > T_RFC) ? MAX_RA : T_RFC;
  localparam int CNT_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam int REFI_W = (T_REFI > 1) ? $clog2(T_REFI) : 1;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_DES = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE, S_ACT, S_RCD, S_RW, S_WAIT, S_REF, S_RFC
  } state_e;

  typedef struct packed {
    logic        write;
    logic [1:0]  bank;
    logic [14:0] row;
    logic [9:0]  col;
  } req_t;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [REFI_W-1:0]  refi_cnt_q, refi_cnt_d;
  logic               ref_pending_q, ref_pending_d;
  req_t               req_q, req_d;
  logic               cke_q, cke_d;
  logic [3:0]         cmd_q, cmd_d;
  logic [1:0]         ba_q, ba_d;
  logic [14:0]        addr_q, addr_d;
  logic               rd_issued_q, rd_issued_d;
  logic               wr_issued_q, wr_issued_d;
  logic               ref_busy_q, ref_busy_d;
  logic               ref_wrap;

  assign req_ready = (state_q == S_IDLE) && init_done && !ref_pending_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    refi_cnt_d    = refi_cnt_q;
    ref_pending_d = ref_pending_q;
    req_d         = req_q;
    ref_wrap      = 1'b0;
    cke_d         = 1'b1;
    cmd_d         = CMD_NOP;
    ba_d          = '0;
    addr_d        = '0;
    rd_issued_d   = 1'b0;
    wr_issued_d   = 1'b0;
    ref_busy_d    = 1'b0;

    if (!init_done) begin
      refi_cnt_d = '0;
    end else if (refi_cnt_q == REFI_W'(T_REFI - 1)) begin
      refi_cnt_d = '0;
      ref_wrap   = 1'b1;
    end else begin
      refi_cnt_d = refi_cnt_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (init_done && ref_pending_q) begin
          state_d       = S_REF;
          ref_pending_d = 1'b0;
        end else if (req_valid && req_ready) begin
          req_d   = '{write: req_write, bank: req_bank, row: req_row, col: req_col};
          state_d = S_ACT;
        end
      end
      S_ACT: begin
        if (T_RCD > 1) begin
          state_d    = S_RCD;
          wait_cnt_d = CNT_W'(T_RCD - 1);
        end else begin
          state_d = S_RW;
        end
      end
      S_RCD: begin
        if (wait_cnt_q == CNT_W'(1)) state_d = S_RW;
        else                         wait_cnt_d = wait_cnt_q - 1'b1;
      end
      S_RW: begin
        if (T_AP > 1) begin
          state_d    = S_WAIT;
          wait_cnt_d = CNT_W'(T_AP - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q == CNT_W'(1)) state_d = S_IDLE;
        else                         wait_cnt_d = wait_cnt_q - 1'b1;
      end
      S_REF: begin
        if (T_RFC > 1) begin
          state_d    = S_RFC;
          wait_cnt_d = CNT_W'(T_RFC - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RFC: begin
        if (wait_cnt_q == CNT_W'(1)) state_d = S_IDLE;
        else                         wait_cnt_d = wait_cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // A wrap while a refresh is already owed leaves a single refresh pending.
    if (ref_wrap) ref_pending_d = 1'b1;

    unique case (state_d)
      S_ACT: begin
        cmd_d  = CMD_ACT;
        ba_d   = req_d.bank;
        addr_d = req_d.row;
      end
      S_RW: begin
        cmd_d       = req_d.write ? CMD_WR : CMD_RD;
        ba_d        = req_d.bank;
        addr_d      = {4'b0000, 1'b1, req_d.col};
        rd_issued_d = !req_d.write;
        wr_issued_d = req_d.write;
      end
      S_REF: begin
        cmd_d      = CMD_REF;
        ref_busy_d = 1'b1;
      end
      S_RFC:   ref_busy_d = 1'b1;
      default: cmd_d = CMD_NOP;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wait_cnt_q    <= '0;
      refi_cnt_q    <= '0;
      ref_pending_q <= 1'b0;
      req_q         <= '0;
      cke_q         <= 1'b0;
      cmd_q         <= CMD_DES;
      ba_q          <= '0;
      addr_q        <= '0;
      rd_issued_q   <= 1'b0;
      wr_issued_q   <= 1'b0;
      ref_busy_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      refi_cnt_q    <= refi_cnt_d;
      ref_pending_q <= ref_pending_d;
      req_q         <= req_d;
      cke_q         <= cke_d;
      cmd_q         <= cmd_d;
      ba_q          <= ba_d;
      addr_q        <= addr_d;
      rd_issued_q   <= rd_issued_d;
      wr_issued_q   <= wr_issued_d;
      ref_busy_q    <= ref_busy_d;
    end
  end

  assign cke                      = cke_q;
  assign {cs_n, ras_n, cas_n, we_n} = cmd_q;
  assign ba                       = ba_q;
  assign addr                     = addr_q;
  assign rd_issued                = rd_issued_q;
  assign wr_issued                = wr_issued_q;
  assign ref_busy                 = ref_busy_q;

endmodule

// File: tb/tb_ddr2_cmd_sequencer.sv
// Scoreboard bench: instance A uses default timing, instance B uses T_RCD=1 and T_REFI=100.
// Stimulus pushes expected commands with their cycle numbers; per-instance monitors pop and compare.
module tb_ddr2_cmd_sequencer;

  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101;
  localparam logic [3:0] WR  = 4'b0100, REF = 4'b0001, DES = 4'b1111;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [14:0] addr;
    logic        rd;
    logic        wr;
    logic        busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  exp_t qa[$];
  exp_t qb[$];

  logic a_init, a_valid, a_ready, a_write, a_cke, a_cs_n, a_ras_n, a_cas_n, a_we_n, a_rd, a_wr, a_busy;
  logic [1:0] a_bank, a_ba;
  logic [14:0] a_row, a_addr;
  logic [9:0] a_col;
  logic b_init, b_valid, b_ready, b_write, b_cke, b_cs_n, b_ras_n, b_cas_n, b_we_n, b_rd, b_wr, b_busy;
  logic [1:0] b_bank, b_ba;
  logic [14:0] b_row, b_addr;
  logic [9:0] b_col;
  logic [3:0] cmd_a, cmd_b;
  assign cmd_a = {a_cs_n, a_ras_n, a_cas_n, a_we_n};
  assign cmd_b = {b_cs_n, b_ras_n, b_cas_n, b_we_n};

  ddr2_cmd_sequencer dut_a (
    .clk(clk), .rst_n(rst_n), .init_done(a_init), .req_valid(a_valid), .req_ready(a_ready),
    .req_write(a_write), .req_bank(a_bank), .req_row(a_row), .req_col(a_col), .cke(a_cke),
    .cs_n(a_cs_n), .ras_n(a_ras_n), .cas_n(a_cas_n), .we_n(a_we_n), .ba(a_ba), .addr(a_addr),
    .rd_issued(a_rd), .wr_issued(a_wr), .ref_busy(a_busy)
  );

  ddr2_cmd_sequencer #(.T_RCD(1), .T_AP(8), .T_RFC(26), .T_REFI(100)) dut_b (
    .clk(clk), .rst_n(rst_n), .init_done(b_init), .req_valid(b_valid), .req_ready(b_ready),
    .req_write(b_write), .req_bank(b_bank), .req_row(b_row), .req_col(b_col), .cke(b_cke),
    .cs_n(b_cs_n), .ras_n(b_ras_n), .cas_n(b_cas_n), .we_n(b_we_n), .ba(b_ba), .addr(b_addr),
    .rd_issued(b_rd), .wr_issued(b_wr), .ref_busy(b_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input int unsigned c, input logic [3:0] cmd, input logic [1:0] ba,
                              input logic [14:0] addr, input logic rd, input logic wr, input logic busy);
    exp_t e;
    e.cyc = c; e.cmd = cmd; e.ba = ba; e.addr = addr; e.rd = rd; e.wr = wr; e.busy = busy;
    return e;
  endfunction

  task automatic compare(input string tag, input exp_t e, input logic [3:0] cmd, input logic [1:0] ba,
                         input logic [14:0] addr, input logic rd, input logic wr, input logic busy);
    check({tag, "_cycle"}, cyc, e.cyc);
    check({tag, "_cmd"}, 32'(cmd), 32'(e.cmd));
    check({tag, "_ba"}, 32'(ba), 32'(e.ba));
    check({tag, "_addr"}, 32'(addr), 32'(e.addr));
    check({tag, "_issued"}, {29'd0, rd, wr, busy}, {29'd0, e.rd, e.wr, e.busy});
  endtask

  always @(negedge clk) begin
    if (rst_n && cmd_a != DES) begin
      if (cmd_a == NOP) check("a_nop_issue", {30'd0, a_rd, a_wr}, 32'd0);
      else if (qa.size() == 0) check("a_unexpected_cmd", 32'(cmd_a), 32'(NOP));
      else compare("a", qa.pop_front(), cmd_a, a_ba, a_addr, a_rd, a_wr, a_busy);
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmd_b != DES) begin
      if (cmd_b == NOP) check("b_nop_issue", {30'd0, b_rd, b_wr}, 32'd0);
      else if (qb.size() == 0) check("b_unexpected_cmd", 32'(cmd_b), 32'(NOP));
      else compare("b", qb.pop_front(), cmd_b, b_ba, b_addr, b_rd, b_wr, b_busy);
    end
  end

  task automatic wait_until(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  // Called at a negedge; k is the cycle whose closing edge accepts the request.
  task automatic send(input bit sel, input logic w, input logic [1:0] b, input logic [14:0] r,
                      input logic [9:0] c, output int unsigned k);
    int n = 0;
    int unsigned rcd;
    if (sel) begin b_write = w; b_bank = b; b_row = r; b_col = c; b_valid = 1'b1; end
    else     begin a_write = w; a_bank = b; a_row = r; a_col = c; a_valid = 1'b1; end
    #1;
    while (!(sel ? b_ready : a_ready) && n < 200) begin
      @(negedge clk); #1; n++;
    end
    check("accept_in_time", 32'(n < 200), 32'd1);
    k   = cyc;
    rcd = sel ? 1 : 3;
    if (sel) begin
      qb.push_back(mk(k + 1, ACT, b, r, 1'b0, 1'b0, 1'b0));
      qb.push_back(mk(k + 1 + rcd, w ? WR : RD, b, {4'b0, 1'b1, c}, !w, w, 1'b0));
    end else begin
      qa.push_back(mk(k + 1, ACT, b, r, 1'b0, 1'b0, 1'b0));
      qa.push_back(mk(k + 1 + rcd, w ? WR : RD, b, {4'b0, 1'b1, c}, !w, w, 1'b0));
    end
    @(negedge clk);
    if (sel) b_valid = 1'b0;
    else     a_valid = 1'b0;
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_cke"}, 32'(a_cke), 32'd0);
    check({tag, "_pins"}, 32'(cmd_a), 32'(DES));
    check({tag, "_ba_addr"}, {15'd0, a_ba, a_addr}, 32'd0);
    check({tag, "_flags"}, {29'd0, a_rd, a_wr, a_busy}, 32'd0);
  endtask

  initial begin
    int unsigned k, c, n0;
    {a_init, a_valid, a_write, a_bank, a_row, a_col} = '0;
    {b_init, b_valid, b_write, b_bank, b_row, b_col} = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_a("rst_a");
    check("rst_b_pins", {27'd0, b_cke, cmd_b}, {27'd0, 1'b0, DES});
    rst_n = 1'b1;
    @(negedge clk);
    check("a_cke_after_rst", 32'(a_cke), 32'd1);
    check("a_nop_after_rst", 32'(cmd_a), 32'(NOP));
    check("b_cke_after_rst", 32'(b_cke), 32'd1);
    check("a_ready_init_low", 32'(a_ready), 32'd0);

    // Read with default timing: ACT k+1, RD k+4, ready again at k+12.
    a_init = 1'b1;
    send(1'b0, 1'b0, 2'd2, 15'h1234, 10'h05A, k);
    wait_until(k + 11);
    check("a_ready_before_idle", 32'(a_ready), 32'd0);
    @(negedge clk);
    check("a_ready_back", 32'(a_ready), 32'd1);

    // Write then asynchronous reset in the WAIT phase.
    send(1'b0, 1'b1, 2'd3, 15'h7FFF, 10'h200, k);
    wait_until(k + 6);
    rst_n = 1'b0;
    #1 check_reset_a("rst_mid_wait");
    repeat (2) begin
      @(negedge clk);
      check_reset_a("rst_held");
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("a_cke_after_midrst", 32'(a_cke), 32'd1);
    check("a_nop_after_midrst", 32'(cmd_a), 32'(NOP));
    check("a_ready_after_midrst", 32'(a_ready), 32'd1);
    repeat (15) @(negedge clk);

    // init_done low blocks acceptance; raising it accepts in the same cycle.
    a_init = 1'b0;
    a_write = 1'b0; a_bank = 2'd0; a_row = 15'h0001; a_col = 10'h001; a_valid = 1'b1;
    repeat (50) begin
      @(negedge clk);
      check("a_ready_while_uninit", 32'(a_ready), 32'd0);
    end
    a_init = 1'b1;
    n0 = cyc;
    send(1'b0, 1'b0, 2'd0, 15'h0001, 10'h001, k);
    check("a_accept_same_cycle", k, n0);
    wait_until(k + 13);
    a_init = 1'b0;

    // Instance B: write with T_RCD=1, then refresh period and refresh/request collision.
    @(negedge clk);
    c = cyc;
    b_init = 1'b1;
    send(1'b1, 1'b1, 2'd1, 15'h2222, 10'h3FF, k);
    check("b_accept_cycle", k, c);
    for (int i = 1; i <= 3; i++) qb.push_back(mk(c + 1 + 100 * i, REF, 2'd0, 15'd0, 1'b0, 1'b0, 1'b1));
    qb.push_back(mk(c + 328, ACT, 2'd3, 15'h0005, 1'b0, 1'b0, 1'b0));
    qb.push_back(mk(c + 329, RD, 2'd3, 15'h0410, 1'b1, 1'b0, 1'b0));
    wait_until(c + 9);
    check("b_ready_before_idle", 32'(b_ready), 32'd0);
    @(negedge clk);
    check("b_ready_back", 32'(b_ready), 32'd1);
    for (int p = 1; p <= 2; p++) begin
      wait_until(c + 100 * p);
      check("b_busy_before_ref", 32'(b_busy), 32'd0);
      for (int j = 0; j < 26; j++) begin
        @(negedge clk);
        check("b_busy_during_rfc", 32'(b_busy), 32'd1);
      end
      @(negedge clk);
      check("b_busy_after_rfc", 32'(b_busy), 32'd0);
    end
    wait_until(c + 300);
    b_write = 1'b0; b_bank = 2'd3; b_row = 15'h0005; b_col = 10'h010; b_valid = 1'b1;
    for (int j = 0; j < 27; j++) begin
      #1 check("b_ready_held_by_ref", 32'(b_ready), 32'd0);
      @(negedge clk);
    end
    #1 check("b_ready_after_ref", 32'(b_ready), 32'd1);
    @(negedge clk);
    b_valid = 1'b0;
    wait_until(c + 345);
    check("a_queue_drained", qa.size(), 32'd0);
    check("b_queue_drained", qb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
